// File: rtl/vit_trellis_pkg.sv
// Trellis definitions shared by the convolutional encoder and the Viterbi decoder.
// The register vector is {u, sr[K-2:0]}: the current bit u is the MSB and
// sr[K-2] is the most recent previous bit.
package vit_trellis;

  localparam int cMIN_K = 3;
  localparam int cMAX_K = 9;

  // Register vector wide enough for the largest supported constraint length.
  typedef logic [cMAX_K-1:0] trel_vec_t;

  // Build the full register vector from the incoming bit and the shift register.
  // sr must be zero above bit k-2.
  function automatic trel_vec_t reg_vec(input logic u, input trel_vec_t sr, input int k);
    return sr | (trel_vec_t'(u) << (k - 1));
  endfunction

  // Shift register after consuming u: u enters bit k-2, bit 0 falls off.
  function automatic trel_vec_t next_sr(input logic u, input trel_vec_t sr, input int k);
    return (sr >> 1) | (trel_vec_t'(u) << (k - 2));
  endfunction

  // One generator output: parity of the taps selected by the polynomial.
  function automatic logic gen_bit(input trel_vec_t poly, input trel_vec_t vec);
    return ^(poly & vec);
  endfunction

endpackage

// File: rtl/vit_enc.sv
// Rate 1/N convolutional encoder with framed input and optional zero tail.
//
// state | meaning
// IDLE  | waiting for an isop bit; other input bits are dropped
// DATA  | encoding frame bits; isop restarts the frame from sr=0
// TAIL  | flushing K-1 zero bits, input stalled (ordy=0)
module vit_enc
  import vit_trellis::*;
#(
  parameter int pCONSTR_LENGTH = 3,
  parameter int pCODE_GEN_NUM  = 2,
  parameter int pCODE_GEN [pCODE_GEN_NUM] = '{6, 7},
  parameter int pTAIL_ENA      = 1
) (
  input  logic                     iclk,
  input  logic                     ireset,
  input  logic                     iclkena,
  input  logic                     isop,
  input  logic                     ival,
  input  logic                     ieop,
  input  logic                     idat,
  output logic                     ordy,
  output logic                     osop,
  output logic                     oval,
  output logic                     oeop,
  output logic [pCODE_GEN_NUM-1:0] odat
);

  localparam int cSR_W  = pCONSTR_LENGTH - 1;
  localparam int cCNT_W = $clog2(pCONSTR_LENGTH);
  // Tail counter runs from K-2 down to 0, giving K-1 tail words.
  localparam logic [cCNT_W-1:0] cTAIL_LOAD = cCNT_W'(pCONSTR_LENGTH - 2);
  localparam logic [cCNT_W-1:0] cCNT_ONE   = cCNT_W'(1);

  localparam logic [1:0] cST_IDLE = 2'd0;
  localparam logic [1:0] cST_DATA = 2'd1;
  localparam logic [1:0] cST_TAIL = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [cSR_W-1:0]         sr_q, sr_d, sr_base;
  logic [cCNT_W-1:0]        tail_cnt_q, tail_cnt_d;
  logic                     accept, data_fire, in_tail, tail_last;
  logic                     word_fire, word_sop, word_eop, u_bit;
  trel_vec_t                code_vec;
  logic [pCODE_GEN_NUM-1:0] code_w;
  logic                     osop_q, oval_q, oeop_q;
  logic [pCODE_GEN_NUM-1:0] odat_q;

  assign in_tail   = (state_q == cST_TAIL);
  assign ordy      = ~in_tail;
  assign accept    = iclkena & ival & ordy;
  // A bit is encoded on any accept in DATA, or an isop accept from IDLE.
  assign data_fire = accept & ((state_q == cST_DATA) | isop);
  assign tail_last = in_tail & (tail_cnt_q == '0);
  assign word_fire = data_fire | (iclkena & in_tail);

  // isop always restarts encoding from the all-zero state, also mid-frame.
  assign sr_base  = (data_fire & isop) ? '0 : sr_q;
  assign u_bit    = in_tail ? 1'b0 : idat;
  assign code_vec = reg_vec(u_bit, trel_vec_t'(sr_base), pCONSTR_LENGTH);

  assign word_sop = data_fire & isop;
  assign word_eop = (pTAIL_ENA != 0) ? (iclkena & tail_last) : (data_fire & ieop);

  for (genvar j = 0; j < pCODE_GEN_NUM; j++) begin : g_gen
    assign code_w[j] = gen_bit(pCODE_GEN[j][cMAX_K-1:0], code_vec);
  end

  // Frame sequencing, shift register update and tail counting.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    tail_cnt_d = tail_cnt_q;
    case (state_q)
      cST_IDLE, cST_DATA: begin
        if (data_fire) begin
          sr_d = cSR_W'(next_sr(u_bit, trel_vec_t'(sr_base), pCONSTR_LENGTH));
          if (ieop) begin
            if (pTAIL_ENA != 0) begin
              state_d    = cST_TAIL;
              tail_cnt_d = cTAIL_LOAD;
            end else begin
              state_d = cST_IDLE;
            end
          end else begin
            state_d = cST_DATA;
          end
        end
      end
      cST_TAIL: begin
        if (iclkena) begin
          sr_d = cSR_W'(next_sr(1'b0, trel_vec_t'(sr_q), pCONSTR_LENGTH));
          if (tail_cnt_q == '0) begin
            state_d = cST_IDLE;
          end else begin
            tail_cnt_d = tail_cnt_q - cCNT_ONE;
          end
        end
      end
      default: begin
        state_d    = cST_IDLE;
        sr_d       = '0;
        tail_cnt_d = '0;
      end
    endcase
  end

  // Control state registers; everything holds while iclkena is low.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q    <= cST_IDLE;
      sr_q       <= '0;
      tail_cnt_q <= '0;
    end else if (iclkena) begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      tail_cnt_q <= tail_cnt_d;
    end
  end

  // Registered coded word and framing flags, one cycle after the encoded bit.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      oval_q <= 1'b0;
      osop_q <= 1'b0;
      oeop_q <= 1'b0;
      odat_q <= '0;
    end else if (iclkena) begin
      oval_q <= word_fire;
      osop_q <= word_sop;
      oeop_q <= word_eop;
      if (word_fire) begin
        odat_q <= code_w;
      end
    end
  end

  assign oval = oval_q;
  assign osop = osop_q;
  assign oeop = oeop_q;
  assign odat = odat_q;

endmodule

// File: tb/tb_vit_enc.sv
// Bench for vit_enc: three instances (K=3 with tail, K=3 without tail,
// K=7 {171,133} with tail), a convolution-sum reference model and a
// hard-decision Viterbi decoder for the K=7 frames.
module tb_vit_enc;

  typedef bit bitq_t[$];
  typedef struct {
    bit         sop;
    bit         eop;
    logic [1:0] dat;
    int         cyc;
  } word_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] clkena, isop, ival, ieop, idat;
  logic [2:0] ordy, osop, oval, oeop;
  logic [1:0] odat [3];
  logic [2:0] en_last;

  word_t cap [3][$];
  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ordy1_low = 0;

  always #5 clk = ~clk;

  vit_enc #(.pCONSTR_LENGTH(3), .pCODE_GEN_NUM(2), .pCODE_GEN('{6, 7}), .pTAIL_ENA(1)) u_k3 (
    .iclk(clk), .ireset(rst), .iclkena(clkena[0]), .isop(isop[0]), .ival(ival[0]),
    .ieop(ieop[0]), .idat(idat[0]), .ordy(ordy[0]), .osop(osop[0]), .oval(oval[0]),
    .oeop(oeop[0]), .odat(odat[0]));

  vit_enc #(.pCONSTR_LENGTH(3), .pCODE_GEN_NUM(2), .pCODE_GEN('{6, 7}), .pTAIL_ENA(0)) u_k3nt (
    .iclk(clk), .ireset(rst), .iclkena(clkena[1]), .isop(isop[1]), .ival(ival[1]),
    .ieop(ieop[1]), .idat(idat[1]), .ordy(ordy[1]), .osop(osop[1]), .oval(oval[1]),
    .oeop(oeop[1]), .odat(odat[1]));

  vit_enc #(.pCONSTR_LENGTH(7), .pCODE_GEN_NUM(2), .pCODE_GEN('{'o171, 'o133}), .pTAIL_ENA(1)) u_k7 (
    .iclk(clk), .ireset(rst), .iclkena(clkena[2]), .isop(isop[2]), .ival(ival[2]),
    .ieop(ieop[2]), .idat(idat[2]), .ordy(ordy[2]), .osop(osop[2]), .oval(oval[2]),
    .oeop(oeop[2]), .odat(odat[2]));

  always @(posedge clk) en_last <= clkena;

  // Collect each new coded word (a word that was produced by an enabled edge).
  always @(negedge clk) begin
    word_t w;
    cyc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (oval[i] === 1'b1 && en_last[i] === 1'b1) begin
        w.sop = osop[i];
        w.eop = oeop[i];
        w.dat = odat[i];
        w.cyc = cyc;
        cap[i].push_back(w);
      end
    end
    if (!rst && ordy[1] !== 1'b1) ordy1_low = ordy1_low + 1;
  end

  // Reference: coded bit t = XOR over taps m of g[K-1-m] * u[t-m].
  function automatic bit conv_bit(input int k, input int g, input bitq_t u, input int t);
    bit acc = 1'b0;
    for (int m = 0; m < k; m++)
      if (t - m >= 0 && ((g >> (k - 1 - m)) & 1) == 1) acc ^= u[t - m];
    return acc;
  endfunction

  task automatic add_exp(input int k, input int g0, input int g1, input bitq_t d,
                         input bit tail_on, input bit has_eop);
    bitq_t u = d;
    int    n;
    if (tail_on) for (int z = 0; z < k - 1; z++) u.push_back(1'b0);
    n = u.size();
    for (int t = 0; t < n; t++) begin
      word_t w;
      w.sop = (t == 0);
      w.eop = has_eop && (t == n - 1);
      w.dat = {conv_bit(k, g1, u, t), conv_bit(k, g0, u, t)};
      w.cyc = 0;
      exp_q.push_back(w);
    end
  endtask

  function automatic int first_diff(input int i);
    int n = (cap[i].size() < exp_q.size()) ? cap[i].size() : exp_q.size();
    for (int k = 0; k < n; k++)
      if (cap[i][k].sop !== exp_q[k].sop || cap[i][k].eop !== exp_q[k].eop ||
          cap[i][k].dat !== exp_q[k].dat) return k;
    if (cap[i].size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic string wdesc(input word_t q[$], input int idx);
    if (idx < 0 || idx >= q.size()) return $sformatf("none(n=%0d)", q.size());
    return $sformatf("sop=%0b eop=%0b dat=%b (n=%0d)", q[idx].sop, q[idx].eop, q[idx].dat, q.size());
  endfunction

  function automatic bitq_t rand_bits(input int n);
    bitq_t q;
    for (int k = 0; k < n; k++) q.push_back(bit'($urandom_range(0, 1)));
    return q;
  endfunction

  function automatic bitq_t ref_frame();
    bitq_t q;
    q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b1);
    return q;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 3; i++) cap[i].delete();
    exp_q.delete();
  endtask

  task automatic drive_bit(input int i, input bit s, input bit e, input bit d);
    int guard = 0;
    while (ordy[i] !== 1'b1) begin
      if (guard == 50) begin
        errors++;
        $display("FAIL drive_timeout inst %0d: ordy=%b required 1", i, ordy[i]);
        return;
      end
      guard++;
      @(negedge clk);
    end
    isop[i] = s; ieop[i] = e; idat[i] = d; ival[i] = 1'b1;
    @(negedge clk);
    ival[i] = 1'b0; isop[i] = 1'b0; ieop[i] = 1'b0;
  endtask

  task automatic send_frame(input int i, input bitq_t d);
    for (int k = 0; k < d.size(); k++) drive_bit(i, k == 0, k == d.size() - 1, d[k]);
  endtask

  task automatic wait_words(input int i, input int n);
    int g = 0;
    while (cap[i].size() < n && g < 300) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (cap[i].size() < n) begin
      errors++;
      $display("FAIL word_timeout inst %0d: got %0d words required %0d", i, cap[i].size(), n);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ordy[i], oval[i], osop[i], oeop[i], odat[i]} !== 6'b100000) begin
        errors++;
        $display("FAIL reset_state inst %0d: ordy/oval/osop/oeop/odat=%b required 100000",
                 i, {ordy[i], oval[i], osop[i], oeop[i], odat[i]});
      end
    end
  endtask

  task automatic test_frame_k3();
    bit e0[6] = '{1, 1, 1, 0, 1, 0};
    bit e1[6] = '{1, 1, 0, 0, 0, 1};
    bitq_t f = ref_frame();
    int n = 0, d;
    clear_all();
    for (int t = 0; t < 6; t++) begin
      word_t w;
      w.sop = (t == 0); w.eop = (t == 5); w.dat = {e1[t], e0[t]}; w.cyc = 0;
      exp_q.push_back(w);
    end
    send_frame(0, f);
    while (ordy[0] !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL k3_ordy_low: got %0d cycles required 2", n);
    end
    wait_words(0, 6);
    checks++;
    d = first_diff(0);
    if (d != -1) begin
      errors++;
      $display("FAIL k3_frame word %0d: got %s required %s", d, wdesc(cap[0], d), wdesc(exp_q, d));
    end
  endtask

  task automatic test_no_tail();
    bit e0[4] = '{1, 1, 1, 0};
    bit e1[4] = '{1, 1, 0, 0};
    int d;
    bitq_t r;
    clear_all();
    ordy1_low = 0;
    for (int t = 0; t < 4; t++) begin
      word_t w;
      w.sop = (t == 0); w.eop = (t == 3); w.dat = {e1[t], e0[t]}; w.cyc = 0;
      exp_q.push_back(w);
    end
    send_frame(1, ref_frame());
    wait_words(1, 4);
    checks++;
    d = first_diff(1);
    if (d != -1) begin
      errors++;
      $display("FAIL notail_frame word %0d: got %s required %s", d, wdesc(cap[1], d), wdesc(exp_q, d));
    end
    clear_all();
    for (int f = 0; f < 3; f++) begin
      r = rand_bits((f == 1) ? 1 : $urandom_range(2, 9));
      add_exp(3, 6, 7, r, 1'b0, 1'b1);
      send_frame(1, r);
    end
    wait_words(1, exp_q.size());
    checks++;
    d = first_diff(1);
    if (d != -1) begin
      errors++;
      $display("FAIL notail_random word %0d: got %s required %s", d, wdesc(cap[1], d), wdesc(exp_q, d));
    end
    checks++;
    if (ordy1_low != 0) begin
      errors++;
      $display("FAIL notail_ordy: got %0d low cycles required 0", ordy1_low);
    end
  endtask

  task automatic test_gaps_clkena();
    bit e0[6] = '{1, 1, 1, 0, 1, 0};
    bit e1[6] = '{1, 1, 0, 0, 0, 1};
    logic [5:0] snap;
    int d;
    clear_all();
    for (int t = 0; t < 6; t++) begin
      word_t w;
      w.sop = (t == 0); w.eop = (t == 5); w.dat = {e1[t], e0[t]}; w.cyc = 0;
      exp_q.push_back(w);
    end
    drive_bit(0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive_bit(0, 1'b0, 1'b0, 1'b0);
    clkena[0] = 1'b0;
    ival[0] = 1'b1; idat[0] = 1'b1;
    snap = {ordy[0], oval[0], osop[0], oeop[0], odat[0]};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({ordy[0], oval[0], osop[0], oeop[0], odat[0]} !== snap) begin
        errors++;
        $display("FAIL clkena_hold cycle %0d: got %b required %b", c,
                 {ordy[0], oval[0], osop[0], oeop[0], odat[0]}, snap);
      end
    end
    ival[0] = 1'b0;
    clkena[0] = 1'b1;
    drive_bit(0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive_bit(0, 1'b0, 1'b1, 1'b1);
    wait_words(0, 6);
    checks++;
    d = first_diff(0);
    if (d != -1) begin
      errors++;
      $display("FAIL gaps_frame word %0d: got %s required %s", d, wdesc(cap[0], d), wdesc(exp_q, d));
    end
  endtask

  task automatic test_abort();
    bitq_t a = rand_bits(2);
    bitq_t b = rand_bits($urandom_range(3, 8));
    int d;
    clear_all();
    add_exp(3, 6, 7, a, 1'b0, 1'b0);
    add_exp(3, 6, 7, b, 1'b1, 1'b1);
    drive_bit(0, 1'b1, 1'b0, a[0]);
    drive_bit(0, 1'b0, 1'b0, a[1]);
    send_frame(0, b);
    wait_words(0, exp_q.size());
    checks++;
    d = first_diff(0);
    if (d != -1) begin
      errors++;
      $display("FAIL abort_stream word %0d: got %s required %s", d, wdesc(cap[0], d), wdesc(exp_q, d));
    end
  endtask

  task automatic test_reset_tail();
    bitq_t r;
    int d, eops = 0;
    clear_all();
    send_frame(0, ref_frame());
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ordy[0], oval[0], osop[0], oeop[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_in_tail: ordy/oval/osop/oeop=%b required 1000",
               {ordy[0], oval[0], osop[0], oeop[0]});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    foreach (cap[0][k]) if (cap[0][k].eop) eops++;
    checks++;
    if (eops != 0) begin
      errors++;
      $display("FAIL reset_no_eop: got %0d eop words required 0", eops);
    end
    clear_all();
    r = rand_bits($urandom_range(3, 10));
    add_exp(3, 6, 7, r, 1'b1, 1'b1);
    send_frame(0, r);
    wait_words(0, exp_q.size());
    checks++;
    d = first_diff(0);
    if (d != -1) begin
      errors++;
      $display("FAIL after_reset word %0d: got %s required %s", d, wdesc(cap[0], d), wdesc(exp_q, d));
    end
  endtask

  task automatic test_back_to_back();
    bitq_t r;
    int d;
    clear_all();
    for (int f = 0; f < 4; f++) begin
      r = rand_bits((f == 2) ? 1 : $urandom_range(2, 8));
      add_exp(3, 6, 7, r, 1'b1, 1'b1);
      send_frame(0, r);
    end
    wait_words(0, exp_q.size());
    checks++;
    d = first_diff(0);
    if (d != -1) begin
      errors++;
      $display("FAIL b2b_stream word %0d: got %s required %s", d, wdesc(cap[0], d), wdesc(exp_q, d));
    end
    for (int k = 1; k < cap[0].size(); k++) begin
      if (cap[0][k].sop && cap[0][k-1].eop) begin
        checks++;
        if (cap[0][k].cyc != cap[0][k-1].cyc + 1) begin
          errors++;
          $display("FAIL b2b_gap word %0d: got %0d cycles required 1", k, cap[0][k].cyc - cap[0][k-1].cyc);
        end
      end
    end
  endtask

  // Hard-decision Viterbi over the captured K=7 words, traced back from state 0.
  task automatic viterbi_check(input bitq_t d, input int f);
    int pm[64], npm[64];
    int vprev[64][64];
    bit vbit[64][64];
    bitq_t dec;
    int n = cap[2].size();
    int best = 0, st = 0, bad = 0;
    if (n > 64) n = 64;
    for (int s = 0; s < 64; s++) pm[s] = (s == 0) ? 0 : 1000000;
    for (int t = 0; t < n; t++) begin
      for (int s = 0; s < 64; s++) npm[s] = 1000000;
      for (int s = 0; s < 64; s++) begin
        if (pm[s] < 1000000) begin
          for (int u = 0; u < 2; u++) begin
            int vec = (u << 6) | s;
            int o0 = $countones(vec & 'o171) & 1;
            int o1 = $countones(vec & 'o133) & 1;
            int bm = ((o0 == 1) != (cap[2][t].dat[0] === 1'b1) ? 1 : 0) +
                     ((o1 == 1) != (cap[2][t].dat[1] === 1'b1) ? 1 : 0);
            int ns = (u << 5) | (s >> 1);
            if (pm[s] + bm < npm[ns]) begin
              npm[ns] = pm[s] + bm;
              vprev[t][ns] = s;
              vbit[t][ns] = bit'(u);
            end
          end
        end
      end
      pm = npm;
    end
    for (int s = 1; s < 64; s++) if (pm[s] < pm[best]) best = s;
    checks++;
    if (best != 0 || pm[0] != 0) begin
      errors++;
      $display("FAIL k7_end_state frame %0d: got state %0d metric %0d required state 0 metric 0", f, best, pm[best]);
    end
    for (int t = n - 1; t >= 0; t--) begin
      dec.push_front(vbit[t][st]);
      st = vprev[t][st];
    end
    for (int k = 0; k < d.size(); k++) if (k >= dec.size() || dec[k] != d[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL k7_decode frame %0d: got %0d bit errors required 0", f, bad);
    end
  endtask

  task automatic test_k7_random();
    bitq_t r;
    int d;
    for (int f = 0; f < 4; f++) begin
      clear_all();
      r = rand_bits($urandom_range(8, 40));
      add_exp(7, 'o171, 'o133, r, 1'b1, 1'b1);
      send_frame(2, r);
      wait_words(2, exp_q.size());
      checks++;
      d = first_diff(2);
      if (d != -1) begin
        errors++;
        $display("FAIL k7_stream frame %0d word %0d: got %s required %s", f, d, wdesc(cap[2], d), wdesc(exp_q, d));
      end
      viterbi_check(r, f);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clkena = 3'b111;
    isop = '0; ival = '0; ieop = '0; idat = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_frame_k3();
    test_no_tail();
    test_gaps_clkena();
    test_abort();
    test_reset_tail();
    test_back_to_back();
    test_k7_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vit_enc.md
VIT_ENC -- requirements
Module: vit_enc

Interface
REQ-001 Parameter pCONSTR_LENGTH, default 3, constraint length K (K-1 state bits), legal 3..9.
REQ-002 Parameter pCODE_GEN_NUM, default 2, number of generator polynomials N (code rate 1/N).
REQ-003 Parameter pCODE_GEN[pCODE_GEN_NUM], default '{6, 7}, generator polynomials, K bits each, octal-style integers.
REQ-004 Parameter pTAIL_ENA, default 1, 1 = append K-1 zero tail bits after each frame, 0 = no tail.
REQ-005 iclk  in  1  clock, all logic on rising edge.
REQ-006 ireset  in  1  asynchronous, active-high reset.
REQ-007 iclkena  in  1  global clock enable; when low, all state and outputs hold.
REQ-008 isop  in  1  first bit of frame, qualified by ival.
REQ-009 ival  in  1  input bit valid.
REQ-010 ieop  in  1  last bit of frame, qualified by ival.
REQ-011 idat  in  1  information bit.
REQ-012 ordy  out  1  encoder accepts input this cycle.
REQ-013 osop  out  1  first coded word of frame.
REQ-014 oval  out  1  coded word valid.
REQ-015 oeop  out  1  last coded word of frame, tail included.
REQ-016 odat  out  pCODE_GEN_NUM  coded word; bit j is generator j output.

Function
REQ-017 Accept = iclkena & ival & ordy; an input bit is consumed only on accept.
REQ-018 Shift register sr holds the K-1 previous bits, sr[K-2] most recent; the register vector is {u, sr[K-2:0]} with u in the MSB.
REQ-019 odat[j] = XOR-reduce(pCODE_GEN[j] & {u, sr}), registered, so the word appears one cycle after accept (latency 1).
REQ-020 On accept: sr shifts, u enters sr[K-2], and the oldest bit is dropped.
REQ-021 FSM states: IDLE, DATA, TAIL.
REQ-022 IDLE: ordy=1; accept with isop -> DATA, and encoding starts from sr=0; accept without isop is ignored, with no output.
REQ-023 DATA: ordy=1; accept with ieop -> TAIL if pTAIL_ENA, else -> IDLE.
REQ-024 TAIL: ordy=0, u=0 forced; tail counter runs K-1 cycles, one word per iclkena cycle, then -> IDLE.
REQ-025 isop & ieop on the same accept is a one-bit frame; it follows the ieop rule.
REQ-026 isop accepted in DATA aborts the current frame: no oeop for it, sr cleared, new frame starts, state stays DATA.
REQ-027 oval = 1 exactly one cycle after each accepted data bit in DATA (or in IDLE with isop), and after each TAIL cycle.
REQ-028 osop marks the word of the isop bit; oeop marks the last tail word (pTAIL_ENA=1) or the ieop word (pTAIL_ENA=0).
REQ-029 Back-to-back frames: isop may be accepted in the cycle after TAIL ends, with no gap besides the K-1 tail cycles.

Reset
REQ-030 ireset async-clears: FSM -> IDLE, sr=0, tail counter=0, oval=osop=oeop=0, odat=0, ordy=1 (combinational from IDLE).
REQ-031 Reset mid-frame or mid-tail discards the frame; no oeop is issued.

Structure
REQ-032 Trellis constants and the function computing the generator output belong in the shared vit_trellis package, common with the decoder.
REQ-033 The FSM state enum is local to the module.
REQ-034 Single module, no sub-modules; N generator XOR trees produced by a generate loop.

Verification
REQ-035 K=3, gens {6,7}, tail on; frame 1,0,1,1 -> odat[0] sequence 1,1,1,0,1,0; odat[1] sequence 1,1,0,0,0,1; osop on word 1, oeop on word 6; ordy low for 2 cycles after ieop.
REQ-036 Same frame with pTAIL_ENA=0 -> four words, odat[0]=1,1,1,0, odat[1]=1,1,0,0, oeop on word 4, ordy never low.
REQ-037 ival toggling 1,0,1,0 and iclkena low for 3 cycles mid-frame -> outputs identical to REQ-035 apart from timing; nothing changes while iclkena=0.
REQ-038 isop reasserted after 2 bits of a frame -> no oeop for the first frame; the new frame output matches an encode from sr=0.
REQ-039 ireset pulse during TAIL -> oval=0 immediately, ordy=1, and the next frame encodes correctly from sr=0.
REQ-040 Random frames with K=7, gens {171,133} octal -> the bench decodes them with the team's Viterbi decoder, no errors, and the decoder ends in state 0.
